// File: rtl/router_pkg.sv
// Shared definitions for the router packet FIFO slice.
// Provides default widths, header length-field positions, an address-width
// helper and the default-width storage entry layout {sop flag, data}.
package router_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned LEN_MSB_DEF = 7;
    localparam int unsigned LEN_LSB_DEF = 2;

    // Ceiling log2; used for pointer/address widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Stored word at the default width: header flag sits above the data byte.
    typedef struct packed {
        logic                  sop;
        logic [DATA_W_DEF-1:0] data;
    } router_entry_t;

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read bus of the router packet FIFO.
// master: the router side (issues write_enb/sop_in/data_in and read_enb,
//         observes data/status).
// slave : the FIFO itself.
interface router_pkt_fifo_if
    import router_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LEN_MSB = LEN_MSB_DEF,
    parameter int unsigned LEN_LSB = LEN_LSB_DEF
);
    localparam int unsigned AW   = clog2(DEPTH);
    localparam int unsigned LENW = LEN_MSB - LEN_LSB + 2;

    logic              write_enb;
    logic              sop_in;
    logic [DATA_W-1:0] data_in;
    logic              read_enb;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [AW:0]       count;
    logic [AW:0]       pkt_count;
    logic [LENW-1:0]   rd_bytes_left;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output write_enb, sop_in, data_in, read_enb,
        input  data_out, data_valid, empty, full, almost_full, count,
               pkt_count, rd_bytes_left, overflow_err, underflow_err
    );

    modport slave (
        input  write_enb, sop_in, data_in, read_enb,
        output data_out, data_valid, empty, full, almost_full, count,
               pkt_count, rd_bytes_left, overflow_err, underflow_err
    );

endinterface

// File: rtl/router_fifo_ram.sv
// Storage array for the router packet FIFO.
// Ports: clock; we/waddr/wdata synchronous write; raddr -> rdata_c
// asynchronous (combinational) read.
module router_fifo_ram
    import router_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W_DEF + 1,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO between the router write side and a
// destination port read side.
// Ports: clock; reset (sync, active-high); soft_reset (sync flush);
// bus (slave): write_enb/sop_in/data_in, read_enb, registered data_out and
// data_valid, empty/full/almost_full, count, pkt_count, rd_bytes_left,
// sticky overflow_err/underflow_err.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned LEN_MSB  = LEN_MSB_DEF,
    parameter int unsigned LEN_LSB  = LEN_LSB_DEF,
    parameter int unsigned AFULL_TH = DEPTH - 2
) (
    input logic              clock,
    input logic              reset,
    input logic              soft_reset,
    router_pkt_fifo_if.slave bus
);

    localparam int unsigned AW   = clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned FW   = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned LENW = FW + 1;
    localparam int unsigned EW   = DATA_W + 1;

    typedef struct packed {
        logic              sop;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     pkt_count_q;
    logic [LENW-1:0]   rd_bytes_left_q;
    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              flush;
    logic              empty_c;
    logic              full_c;
    logic              wr_ok;
    logic              rd_ok;
    logic              pkt_inc;
    logic              pkt_dec;
    logic [EW-1:0]     ram_rdata_c;
    entry_t            wr_entry;
    entry_t            rd_entry;
    logic [FW-1:0]     len_field;

    // Accept/flag decode from registered pointers; a flush swallows requests.
    always_comb begin
        flush     = reset | soft_reset;
        empty_c   = (wr_ptr == rd_ptr);
        full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        wr_ok     = bus.write_enb && !full_c && !flush;
        rd_ok     = bus.read_enb && !empty_c && !flush;
        wr_entry  = '{sop: bus.sop_in, data: bus.data_in};
        rd_entry  = entry_t'(ram_rdata_c);
        pkt_inc   = wr_ok && bus.sop_in;
        pkt_dec   = rd_ok && rd_entry.sop;
        len_field = rd_entry.data[LEN_MSB:LEN_LSB];
    end

    router_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .we      (wr_ok),
        .waddr   (wr_ptr[AW-1:0]),
        .wdata   (EW'(wr_entry)),
        .raddr   (rd_ptr[AW-1:0]),
        .rdata_c (ram_rdata_c)
    );

    // Pointers, occupancy, packet tracking, read register and sticky errors.
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count_q         <= '0;
            pkt_count_q     <= '0;
            rd_bytes_left_q <= '0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + CW'(1);
            end

            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (pkt_inc && !pkt_dec) begin
                pkt_count_q <= pkt_count_q + CW'(1);
            end else if (pkt_dec && !pkt_inc) begin
                pkt_count_q <= pkt_count_q - CW'(1);
            end

            // Header load covers payload plus the trailing parity word.
            if (rd_ok) begin
                data_out_q <= rd_entry.data;
                if (rd_entry.sop) begin
                    rd_bytes_left_q <= LENW'(len_field) + LENW'(1);
                end else if (rd_bytes_left_q != '0) begin
                    rd_bytes_left_q <= rd_bytes_left_q - LENW'(1);
                end
            end
            data_valid_q <= rd_ok;

            if (bus.write_enb && full_c) begin
                overflow_q <= 1'b1;
            end
            if (bus.read_enb && empty_c) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.data_out      = data_out_q;
    assign bus.data_valid    = data_valid_q;
    assign bus.empty         = empty_c;
    assign bus.full          = full_c;
    assign bus.almost_full   = (count_q >= CW'(AFULL_TH));
    assign bus.count         = count_q;
    assign bus.pkt_count     = pkt_count_q;
    assign bus.rd_bytes_left = rd_bytes_left_q;
    assign bus.overflow_err  = overflow_q;
    assign bus.underflow_err = underflow_q;

endmodule

// File: doc/router_pkt_fifo.md
# router_pkt_fifo

Parametrised, packet-aware synchronous FIFO that succeeds the fixed 16x8 per-port router FIFO. It sits between the router synchroniser/FSM write side and each destination port's read side. It generalises data width and depth and adds an explicit header marker aligned with the data. It also provides a registered data_valid, occupancy, almost_full, stored-packet count and sticky overflow/underflow flags.

## Interface
- DATA_W, 8: payload byte width.
- DEPTH, 16: entries; power of two, >= 4.
- LEN_MSB, 7: MSB of the payload-length field in a header word.
- LEN_LSB, 2: LSB of the payload-length field in a header word.
- AFULL_TH, DEPTH-2: almost_full asserts when count >= AFULL_TH.
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous flush (port timeout); same effect as reset.
- write_enb  in  1  write request.
- sop_in  in  1  data_in is a header word, same cycle as write_enb.
- data_in  in  DATA_W  write data.
- read_enb  in  1  read request.
- data_out  out  DATA_W  registered read data.
- data_valid  out  1  data_out carries a word read in the previous cycle.
- empty  out  1  no entries.
- full  out  1  DEPTH entries.
- almost_full  out  1  count >= AFULL_TH.
- count  out  AW+1  occupancy, 0..DEPTH (AW = clog2(DEPTH)).
- pkt_count  out  AW+1  header words currently stored.
- rd_bytes_left  out  LEN_MSB-LEN_LSB+2  words of the current packet still to be read.
- overflow_err  out  1  sticky; write_enb while full.
- underflow_err  out  1  sticky; read_enb while empty.

## Operation
- Storage is DEPTH x (DATA_W+1). Bit DATA_W holds sop_in. The header flag is captured with the data in the same cycle, with no delay stage.
- Pointers are AW+1 bits. empty is (wr_ptr == rd_ptr). full is when the MSBs differ and the low AW bits are equal. Pointers wrap naturally at 2^(AW+1).
- A write is accepted iff write_enb && !full. A read is accepted iff read_enb && !empty. Both flags are evaluated on current-cycle pointers.
- Simultaneous accepted read and write: both pointers advance and count is unchanged. At full, a simultaneous read does not enable the write in the same cycle.
- count: +1 on write only, -1 on read only, otherwise unchanged.
- pkt_count:
  - +1 on an accepted write with sop_in.
  - -1 on an accepted read of an entry whose flag is set.
  - Unchanged when both happen in the same cycle.
- rd_bytes_left, on an accepted read:
  - Header entry: load word[LEN_MSB:LEN_LSB] + 1 (payload plus parity).
  - Non-header entry with a non-zero value: decrement.
  - Saturates at 0 and never underflows.
- Rejected requests:
  - write_enb && full sets overflow_err; no storage or pointer change.
  - read_enb && empty sets underflow_err; no storage or pointer change.
- reset or soft_reset clears pointers, count, pkt_count, rd_bytes_left, data_out, data_valid and both error flags. Storage contents are not cleared; they are don't-care after a flush.
- reset/soft_reset mid-operation: any request in that cycle is ignored. The FIFO is empty on the next cycle.
- data_out holds its last value when no read is accepted. There is no high-Z drive.

## Timing
- Reset values:
  - data_out 0, data_valid 0, count 0, pkt_count 0, rd_bytes_left 0.
  - empty 1, full 0, almost_full 0, both error flags 0.
- Write latency: a word written in cycle N is readable, with empty deasserted, in cycle N+1.
- Read latency: read accepted in cycle N gives data_out/data_valid valid in cycle N+1. data_valid is a one-cycle pulse per accepted read.
- empty, full and almost_full are combinational from registered pointers/count, so they have no extra lag.
- count, pkt_count and rd_bytes_left update on the same edge as the pointers.
- Error flags set on the edge following the offending request.

## Structure
- Package router_pkg:
  - Default DATA_W.
  - Header length field positions (LEN_MSB, LEN_LSB).
  - Address-width function (clog2).
  - Entry type {flag, data}.
- Sub-module router_fifo_ram: DEPTH x (DATA_W+1), one synchronous write port, one asynchronous read port indexed by rd_ptr[AW-1:0].
- Pointer, counter, flag and output-register logic lives in router_pkt_fifo.

## Test plan
- Reset then single header: write 0x0C with sop_in=1, then 3 payload words and 1 parity word, then read 5. Required:
  - data_valid pulses 5 times.
  - rd_bytes_left goes 4,3,2,1,0.
  - pkt_count goes 1 -> 0.
  - empty=1 at end.
- Fill DEPTH=16 with 16 writes. Required:
  - full=1, count=16.
  - almost_full asserted from count=14.
  - 17th write sets overflow_err with count still 16.
  - Read back gives the values in order.
- Simultaneous read+write at count=8 for 20 cycles. Required:
  - count stays 8.
  - Pointers wrap past 31 -> 0.
  - Data order is preserved.
- read_enb on an empty FIFO. Required: underflow_err=1, data_valid stays 0, data_out unchanged.
- soft_reset asserted with count=5, pkt_count=2 and a concurrent write. Required:
  - Next cycle: empty=1, count=0, pkt_count=0, data_valid=0, errors cleared.
  - The concurrent write is discarded.
- Parameter sweep DATA_W=16, DEPTH=64, LEN_MSB=13, LEN_LSB=2: header 0x0FFC loads rd_bytes_left=1024 and counts down to 0 after 1024 further reads.
